// File: rtl/regfile_writeback.sv
// Write-back stage for the integer register file: arbitrates ALU and LSU results
// onto a registered write port and tracks outstanding loads per destination register.
module regfile_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic                  alu_valid,
    input  logic                  alu_wen,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH:0]   pending_cnt,
    output logic                  sb_err
);

    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_RD = {ADDR_WIDTH{1'b0}};

    // Bit 0 of busy_r is never set, so index 0 always reads as idle.
    logic [NREG-1:0]       busy_r;
    logic [NREG-1:0]       busy_nxt_s;
    logic                  wen_r;
    logic                  wb_lsu_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [DATA_WIDTH-1:0] wr_data_r;
    logic [ADDR_WIDTH:0]   pending_r;
    logic [ADDR_WIDTH:0]   pending_nxt_s;
    logic                  sb_err_r;

    logic lsu_fire_s;
    logic alu_fire_s;
    logic sb_set_s;
    logic sb_clr_s;
    logic sb_err_set_s;

    // Handshake readies, transfer qualifiers and hazard queries.
    always_comb begin
        lsu_ready    = !rst;
        alu_ready    = !rst && !lsu_valid && !(alu_wen && busy_r[alu_rd]);
        issue_ready  = !rst && !busy_r[issue_rd];
        lsu_fire_s   = lsu_valid && lsu_ready;
        alu_fire_s   = alu_valid && alu_ready;
        sb_set_s     = issue_valid && issue_ready && (issue_rd != ZERO_RD);
        // A load only retires once its data sits in the write stage, so busy never
        // drops while the register file still holds the old value.
        sb_clr_s     = wen_r && wb_lsu_r && busy_r[wr_addr_r];
        sb_err_set_s = lsu_fire_s && (lsu_rd != ZERO_RD) && !busy_r[lsu_rd];
        rs1_busy     = busy_r[rs1_addr];
        rs2_busy     = busy_r[rs2_addr];
    end

    // Next scoreboard contents and outstanding-load count.
    always_comb begin
        busy_nxt_s = busy_r;
        if (sb_set_s) begin
            busy_nxt_s[issue_rd] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (sb_clr_s) begin
            busy_nxt_s[wr_addr_r] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;

        case ({sb_set_s, sb_clr_s})
            2'b10:   pending_nxt_s = pending_r + (ADDR_WIDTH + 1)'(1);
            2'b01:   pending_nxt_s = pending_r - (ADDR_WIDTH + 1)'(1);
            default: pending_nxt_s = pending_r;
        endcase
    end

    // State registers: scoreboard, error flag and the register-file write stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r    <= {NREG{1'b0}};
            pending_r <= {(ADDR_WIDTH + 1){1'b0}};
            sb_err_r  <= 1'b0;
            wen_r     <= 1'b0;
            wb_lsu_r  <= 1'b0;
            wr_addr_r <= {ADDR_WIDTH{1'b0}};
            wr_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            busy_r    <= busy_nxt_s;
            pending_r <= pending_nxt_s;
            sb_err_r  <= sb_err_r || sb_err_set_s;
            if (lsu_fire_s) begin
                wen_r     <= (lsu_rd != ZERO_RD);
                wb_lsu_r  <= 1'b1;
                wr_addr_r <= lsu_rd;
                wr_data_r <= lsu_data;
            end else if (alu_fire_s) begin
                wen_r     <= alu_wen && (alu_rd != ZERO_RD);
                wb_lsu_r  <= 1'b0;
                wr_addr_r <= alu_rd;
                wr_data_r <= alu_data;
            end else begin
                wen_r    <= 1'b0;
                wb_lsu_r <= 1'b0;
            end
        end
    end

    assign wen         = wen_r;
    assign wr_addr     = wr_addr_r;
    assign wr_data     = wr_data_r;
    assign pending_cnt = pending_r;
    assign sb_err      = sb_err_r;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback; inputs change and outputs
// are sampled 1 time unit after each rising clock edge.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        alu_valid;
    logic        alu_wen;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        wen;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [5:0]  pending_cnt;
    logic        sb_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    regfile_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_wen(alu_wen), .alu_rd(alu_rd),
        .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wen(wen), .wr_addr(wr_addr), .wr_data(wr_data),
        .pending_cnt(pending_cnt), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_rd = 5'd0;
        alu_valid = 1'b0; alu_wen = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick();
        // Handshakes offered during reset must be ignored.
        alu_valid = 1'b1; alu_wen = 1'b1; alu_rd = 5'd3; alu_data = 32'h1111_1111;
        issue_valid = 1'b1; issue_rd = 5'd4;
        settle();
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_lsu_ready", 32'(lsu_ready), 32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd0);
        tick();
        check("rst_wen", 32'(wen), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_pending", 32'(pending_cnt), 32'd0);
        check("rst_sb_err", 32'(sb_err), 32'd0);

        // ALU write to x3
        rst = 1'b0; issue_valid = 1'b0; alu_data = 32'hDEAD_BEEF;
        settle();
        check("alu_ready_x3", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        check("alu_wen_x3", 32'(wen), 32'd1);
        check("alu_addr_x3", 32'(wr_addr), 32'd3);
        check("alu_data_x3", wr_data, 32'hDEAD_BEEF);
        tick();
        check("alu_wen_drop", 32'(wen), 32'd0);
        check("alu_addr_hold", 32'(wr_addr), 32'd3);
        check("alu_data_hold", wr_data, 32'hDEAD_BEEF);

        // Load to x5: issue, then return
        issue_valid = 1'b1; issue_rd = 5'd5;
        settle();
        check("issue_ready_x5", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0; rs1_addr = 5'd5;
        settle();
        check("busy_x5", 32'(rs1_busy), 32'd1);
        check("pending_1", 32'(pending_cnt), 32'd1);
        check("issue_ready_x5_busy", 32'(issue_ready), 32'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'h0000_1234;
        settle();
        check("lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        lsu_valid = 1'b0;
        check("lsu_wen_x5", 32'(wen), 32'd1);
        check("lsu_addr_x5", 32'(wr_addr), 32'd5);
        check("lsu_data_x5", wr_data, 32'h0000_1234);
        check("busy_x5_hold", 32'(rs1_busy), 32'd1);
        check("pending_hold", 32'(pending_cnt), 32'd1);
        tick();
        check("lsu_wen_drop", 32'(wen), 32'd0);
        check("busy_x5_clear", 32'(rs1_busy), 32'd0);
        check("pending_0", 32'(pending_cnt), 32'd0);
        check("sb_err_clean", 32'(sb_err), 32'd0);

        // LSU and ALU together: LSU first, ALU next cycle
        issue_valid = 1'b1; issue_rd = 5'd6;
        tick();
        issue_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h0000_AAAA;
        alu_valid = 1'b1; alu_wen = 1'b1; alu_rd = 5'd8; alu_data = 32'h0000_BBBB;
        settle();
        check("arb_alu_blocked", 32'(alu_ready), 32'd0);
        tick();
        lsu_valid = 1'b0;
        settle();
        check("arb_alu_ready", 32'(alu_ready), 32'd1);
        check("arb_wen_lsu", 32'(wen), 32'd1);
        check("arb_addr_lsu", 32'(wr_addr), 32'd6);
        check("arb_data_lsu", wr_data, 32'h0000_AAAA);
        tick();
        alu_valid = 1'b0;
        check("arb_wen_alu", 32'(wen), 32'd1);
        check("arb_addr_alu", 32'(wr_addr), 32'd8);
        check("arb_data_alu", wr_data, 32'h0000_BBBB);
        tick();
        check("arb_wen_drop", 32'(wen), 32'd0);
        check("arb_pending", 32'(pending_cnt), 32'd0);

        // WAW stall on x7 and duplicate issue
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        alu_valid = 1'b1; alu_wen = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
        settle();
        check("waw_alu_stall", 32'(alu_ready), 32'd0);
        check("waw_issue_blocked", 32'(issue_ready), 32'd0);
        tick();
        issue_valid = 1'b0;
        check("waw_pending_1", 32'(pending_cnt), 32'd1);
        check("waw_no_write", 32'(wen), 32'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_7000;
        tick();
        lsu_valid = 1'b0;
        settle();
        check("waw_stall_wb", 32'(alu_ready), 32'd0);
        check("waw_lsu_addr", 32'(wr_addr), 32'd7);
        check("waw_lsu_data", wr_data, 32'h0000_7000);
        tick();
        check("waw_alu_free", 32'(alu_ready), 32'd1);
        check("waw_gap_wen", 32'(wen), 32'd0);
        tick();
        alu_valid = 1'b0;
        check("waw_alu_wen", 32'(wen), 32'd1);
        check("waw_alu_data", wr_data, 32'h0000_0077);
        tick();

        // x0 on every channel
        alu_valid = 1'b1; alu_wen = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_0005;
        settle();
        check("x0_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        check("x0_alu_wen", 32'(wen), 32'd0);
        check("x0_alu_addr", 32'(wr_addr), 32'd0);
        issue_valid = 1'b1; issue_rd = 5'd0;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0000_0006;
        rs1_addr = 5'd0;
        settle();
        check("x0_issue_ready", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0; lsu_valid = 1'b0;
        check("x0_lsu_wen", 32'(wen), 32'd0);
        check("x0_pending", 32'(pending_cnt), 32'd0);
        check("x0_busy", 32'(rs1_busy), 32'd0);
        check("x0_sb_err", 32'(sb_err), 32'd0);

        // Unexpected load return to x9
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h0000_0999;
        tick();
        lsu_valid = 1'b0;
        check("stray_wen", 32'(wen), 32'd1);
        check("stray_addr", 32'(wr_addr), 32'd9);
        check("stray_sb_err", 32'(sb_err), 32'd1);
        tick();
        check("stray_sb_sticky", 32'(sb_err), 32'd1);

        // Three loads outstanding, then reset mid-stream
        for (int i = 10; i < 13; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(i);
            tick();
        end
        issue_valid = 1'b0; rs1_addr = 5'd10; rs2_addr = 5'd12;
        settle();
        check("three_pending", 32'(pending_cnt), 32'd3);
        check("three_busy_rs1", 32'(rs1_busy), 32'd1);
        check("three_busy_rs2", 32'(rs2_busy), 32'd1);
        alu_valid = 1'b1; alu_wen = 1'b1; alu_rd = 5'd2; alu_data = 32'h0000_0022;
        tick();
        alu_valid = 1'b0;
        check("pre_rst_wen", 32'(wen), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_wen", 32'(wen), 32'd0);
        check("mid_rst_pending", 32'(pending_cnt), 32'd0);
        check("mid_rst_sb_err", 32'(sb_err), 32'd0);
        check("mid_rst_busy1", 32'(rs1_busy), 32'd0);
        check("mid_rst_busy2", 32'(rs2_busy), 32'd0);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
